aq_spsram_1024x16_arb: RTL



---
 rtl/aq_spsram_pkg.sv | 15 +
 rtl/aq_spsram_init_cnt.sv | 24 ++
 rtl/aq_spsram_1024x16_arb.sv | 109 ++++++++++
 3 files changed

// File: rtl/aq_spsram_pkg.sv
// Shared widths, state encoding and pin constants for the IFU 1024x16 SRAM access controller.
package aq_spsram_pkg;

    localparam int AQ_ADDR_WIDTH = 10;
    localparam int AQ_DATA_WIDTH = 16;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Macro write-enable pins are active-low, so all-ones masks every bit.
    localparam logic [AQ_DATA_WIDTH-1:0] WEN_ALL_ONES = '1;

endpackage

// File: rtl/aq_spsram_init_cnt.sv
// Zeroing-sweep address counter: clear restarts at entry 0, inc advances one entry per cycle.
// Wraps after the last entry; last is combinational from the current count.
module aq_spsram_init_cnt #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt,
    output logic             last
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign last = &cnt;

endmodule

// File: rtl/aq_spsram_1024x16_arb.sv
// Single-port SRAM controller: round-robin fill/lookup arbitration, zeroing sweep after reset/flush.
// Grants are combinational (0 cycles), read data 1 cycle after grant; requesters hold until granted.
module aq_spsram_1024x16_arb
    import aq_spsram_pkg::*;
#(
    parameter int ADDR_WIDTH = AQ_ADDR_WIDTH,
    parameter int DATA_WIDTH = AQ_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  flush_req,
    output logic                  init_done,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] wr_wen,
    output logic                  wr_gnt,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_gnt,
    output logic                  rd_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] SRAM_A,
    output logic                  SRAM_CEN,
    output logic                  SRAM_GWEN,
    output logic [DATA_WIDTH-1:0] SRAM_WEN,
    output logic [DATA_WIDTH-1:0] SRAM_D,
    input  logic [DATA_WIDTH-1:0] SRAM_Q
);

    state_t                  state_q, state_d;
    logic                    last_gnt_q;      // 1: write won the most recent tie
    logic                    rd_vld_q;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic                    cnt_last, cnt_inc, cnt_clr;

    aq_spsram_init_cnt #(
        .WIDTH (ADDR_WIDTH)
    ) u_init_cnt (
        .clk  (CLK),
        .rst  (RST),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .cnt  (cnt),
        .last (cnt_last)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_INIT;
            last_gnt_q <= 1'b0;
            rd_vld_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_vld_q <= rd_gnt;
            if (wr_req && rd_req && (wr_gnt || rd_gnt)) begin
                last_gnt_q <= wr_gnt;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_gnt    = 1'b0;
        rd_gnt    = 1'b0;
        cnt_inc   = 1'b0;
        cnt_clr   = 1'b0;
        SRAM_A    = '0;
        SRAM_D    = '0;
        SRAM_CEN  = 1'b1;
        SRAM_GWEN = 1'b1;
        SRAM_WEN  = WEN_ALL_ONES;

        // Pins stay idle while RST is held even though state already reads INIT.
        if (!RST) begin
            if (state_q == ST_INIT) begin
                SRAM_CEN  = 1'b0;
                SRAM_GWEN = 1'b0;
                SRAM_WEN  = '0;
                SRAM_A    = cnt;
                cnt_inc   = 1'b1;
                if (cnt_last) begin
                    state_d = ST_RUN;
                end
            end else if (flush_req) begin
                state_d = ST_INIT;
                cnt_clr = 1'b1;
            end else begin
                if (wr_req && (!rd_req || !last_gnt_q)) begin
                    wr_gnt    = 1'b1;
                    SRAM_CEN  = 1'b0;
                    SRAM_GWEN = 1'b0;
                    SRAM_A    = wr_addr;
                    SRAM_D    = wr_data;
                    SRAM_WEN  = wr_wen;
                end else if (rd_req) begin
                    rd_gnt    = 1'b1;
                    SRAM_CEN  = 1'b0;
                    SRAM_A    = rd_addr;
                end
            end
        end
    end

    assign init_done = (state_q == ST_RUN) && !RST;
    assign rd_vld    = rd_vld_q;
    assign rd_data   = SRAM_Q;

endmodule
